// File: rtl/conv_kernel_scheduler_pkg.sv
// Shared types and elaboration helpers for the convolution kernel scheduler.
// The CONV_SCHED_PERF_EN macro enables the scheduler's stall/starve counters.
package conv_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

   function automatic int groups_f(input int k, input int pe);
      return (k + pe - 1) / pe;
   endfunction

   // Mask of the final group: only the lanes that still map to a real kernel
   function automatic logic [63:0] last_mask_f(input int k, input int pe);
      int rem;
      rem = k % pe;
      if (rem == 0) return {64{1'b1}};
      return (64'd1 << rem) - 64'd1;
   endfunction

endpackage

// File: rtl/conv_kernel_scheduler_if.sv
// Window-in / presentation-out handshake bundle of the kernel scheduler.
// The scheduler takes the slave view, its environment the master view.
interface conv_kernel_scheduler_if
   import conv_pkg::*;
#(
   parameter int DW = 72,
   parameter int GW = 1,
   parameter int PE = 1
) ();
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [GW-1:0] out_group;
   logic [PE-1:0] out_lane_mask;
   logic          out_pixel_last;
   logic          out_image_last;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_group,
      output out_lane_mask, out_pixel_last, out_image_last
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_group,
      input  out_lane_mask, out_pixel_last, out_image_last
   );
endinterface

// File: rtl/conv_kernel_scheduler_fifo.sv
// Small power-of-two window FIFO; caller never pushes when full
// nor pops when empty.
module conv_window_fifo
   import conv_pkg::*;
#(
   parameter  int W     = 8,
   parameter  int DEPTH = 4,
   localparam int AW    = clog2_min1(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          res,
   input  logic          i_push,
   input  logic [W-1:0]  i_data,
   input  logic          i_pop,
   output logic [W-1:0]  o_data,
   output logic [CW-1:0] o_count,
   output logic          o_full,
   output logic          o_empty
);
   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (res) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (i_push) r_wr <= r_wr + AW'(1);
         if (i_pop)  r_rd <= r_rd + AW'(1);
         case ({i_push, i_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr] <= i_data;
   end

   assign o_data  = r_mem[r_rd];
   assign o_count = r_cnt;
   assign o_full  = (r_cnt == CW'(DEPTH));
   assign o_empty = (r_cnt == '0);
endmodule

// File: rtl/conv_kernel_scheduler.sv
// Presents each buffered window once per kernel group to the PE array.
// Define CONV_SCHED_PERF_EN to add stall_cycles / starve_cycles counters.
module conv_kernel_scheduler
   import conv_pkg::*;
#(
   parameter int NumberOfK          = 8,
   parameter int N                  = 3,
   parameter int BitSize            = 8,
   parameter int ImageWidth         = 16,
   parameter int ProcessingElements = 1,
   parameter int FifoDepth          = 4
) (
   input  logic                    clk,
   input  logic                    res,
   conv_kernel_scheduler_if.slave  bus,
   output logic                    busy
`ifdef CONV_SCHED_PERF_EN
   ,
   output logic [31:0]             stall_cycles,
   output logic [31:0]             starve_cycles
`endif
);
   localparam int DW     = N * N * BitSize;
   localparam int PE     = ProcessingElements;
   localparam int GROUPS = groups_f(NumberOfK, PE);
   localparam int GW     = clog2_min1(GROUPS);
   localparam int PIX    = ImageWidth * ImageWidth;
   localparam int PW     = clog2_min1(PIX);
   localparam int CW     = $clog2(FifoDepth + 1);
   localparam logic [63:0]   LM64      = last_mask_f(NumberOfK, PE);
   localparam logic [PE-1:0] LAST_MASK = LM64[PE-1:0];

   state_t        r_state;
   state_t        w_next;
   logic [GW-1:0] r_grp;
   logic [PW-1:0] r_pix;
   logic [DW-1:0] w_head;
   logic [CW-1:0] w_cnt;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_xfer;
   logic          w_pop;
   logic          w_last_grp;
   logic          w_valid;

   assign w_push     = bus.in_valid && !w_full;
   assign w_valid    = (r_state == ISSUE);
   assign w_xfer     = w_valid && bus.out_ready;
   assign w_last_grp = (r_grp == GW'(GROUPS - 1));
   assign w_pop      = w_xfer && w_last_grp;

   conv_window_fifo #(
      .W     (DW),
      .DEPTH (FifoDepth)
   ) u_fifo (
      .clk     (clk),
      .res     (res),
      .i_push  (w_push),
      .i_data  (bus.in_data),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_count (w_cnt),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // A push into an empty FIFO is presented from the very next cycle
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:  if (!w_empty || w_push) w_next = ISSUE;
         ISSUE: if (w_pop && w_cnt == CW'(1) && !w_push) w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (res) begin
         r_state <= IDLE;
         r_grp   <= '0;
         r_pix   <= '0;
      end else begin
         r_state <= w_next;
         if (w_xfer) begin
            if (w_last_grp) begin
               r_grp <= '0;
               r_pix <= (r_pix == PW'(PIX - 1)) ? '0 : r_pix + PW'(1);
            end else begin
               r_grp <= r_grp + GW'(1);
            end
         end
      end
   end

   assign bus.in_ready       = !w_full;
   assign bus.out_valid      = w_valid;
   assign bus.out_data       = w_valid ? w_head : '0;
   assign bus.out_group      = w_valid ? r_grp : '0;
   assign bus.out_pixel_last = w_valid && w_last_grp;
   assign bus.out_image_last = bus.out_pixel_last && (r_pix == PW'(PIX - 1));
   assign bus.out_lane_mask  = !w_valid   ? '0 :
                               w_last_grp ? LAST_MASK : '1;
   assign busy = !w_empty || (r_state != IDLE);

`ifdef CONV_SCHED_PERF_EN
   always_ff @(posedge clk) begin
      if (res) begin
         stall_cycles  <= '0;
         starve_cycles <= '0;
      end else begin
         if (w_valid && !bus.out_ready && stall_cycles != '1)
            stall_cycles <= stall_cycles + 32'd1;
         if (r_state == IDLE && r_pix != '0 && starve_cycles != '1)
            starve_cycles <= starve_cycles + 32'd1;
      end
   end
`endif
endmodule
